// File: rtl/tlc_pkg.sv
// tlc_pkg: phase encoding and lamp constants shared by the intersection scheduler
package tlc_pkg;
   typedef enum logic [2:0] {NS_G, NS_Y, RED_A, EW_G, EW_Y, RED_B} phase_e;
   localparam logic [2:0] LT_RED = 3'b100;
   localparam logic [2:0] LT_YEL = 3'b010;
   localparam logic [2:0] LT_GRN = 3'b001;
endpackage

// File: rtl/phase_timer.sv
// phase_timer: per-phase cycle counter, cleared on phase change, saturating at all-ones
module phase_timer #(
   parameter int CNT_W = 5
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clr,
   output logic [CNT_W-1:0] cnt
);
   always_ff @(posedge clk)
      if (reset || clr) cnt <= '0;
      else if (cnt != '1) cnt <= cnt + CNT_W'(1);
endmodule

// File: rtl/intersection_phase_scheduler.sv
// intersection_phase_scheduler: two-way signal phase FSM with pedestrian walk grants and emergency preemption
module intersection_phase_scheduler
   import tlc_pkg::*;
#(
   parameter int CNT_W     = 5,
   parameter int GREEN_MIN = 8,
   parameter int GREEN_MAX = 16,
   parameter int YELLOW_T  = 3,
   parameter int ALLRED_T  = 2,
   parameter int WALK_T    = 6
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       car_ns,
   input  logic       car_ew,
   input  logic       ped_req_ns,
   input  logic       ped_req_ew,
   input  logic       emerg_ns,
   input  logic       emerg_ew,
   output logic [2:0] north_south,
   output logic [2:0] east_west,
   output logic       walk_ns,
   output logic       walk_ew,
   output logic [2:0] phase
);
   localparam logic [CNT_W-1:0] C_GMIN = CNT_W'(GREEN_MIN - 1);
   localparam logic [CNT_W-1:0] C_GMAX = CNT_W'(GREEN_MAX - 1);
   localparam logic [CNT_W-1:0] C_YEL  = CNT_W'(YELLOW_T - 1);
   localparam logic [CNT_W-1:0] C_RED  = CNT_W'(ALLRED_T - 1);
   localparam logic [CNT_W-1:0] C_WALK = CNT_W'(WALK_T);

   phase_e           state, state_next;
   logic [CNT_W-1:0] cnt;
   logic             ped_lat_ns, ped_lat_ew, walk_gnt_ns, walk_gnt_ew;
   logic             ns_done, ew_done, entry_ns, entry_ew;

   phase_timer #(.CNT_W(CNT_W)) u_timer (
      .clk   (clk),
      .reset (reset),
      .clr   (state_next != state),
      .cnt   (cnt)
   );

   assign ns_done  = cnt >= C_GMIN && (car_ew || ped_lat_ew) && (cnt >= C_GMAX || !car_ns);
   assign ew_done  = cnt >= C_GMIN && (car_ns || ped_lat_ns) && (cnt >= C_GMAX || !car_ew);
   assign entry_ns = state_next == NS_G && state != NS_G;
   assign entry_ew = state_next == EW_G && state != EW_G;

   // NS preemption outranks EW, so only EW_G yields to a simultaneous request
   always_comb begin
      state_next = state;
      case (state)
         NS_G:    state_next = (!emerg_ns && (emerg_ew || ns_done)) ? NS_Y : NS_G;
         NS_Y:    state_next = (cnt == C_YEL) ? RED_A : NS_Y;
         RED_A:   state_next = (cnt == C_RED) ? EW_G : RED_A;
         EW_G:    state_next = (emerg_ns || (!emerg_ew && ew_done)) ? EW_Y : EW_G;
         EW_Y:    state_next = (cnt == C_YEL) ? RED_B : EW_Y;
         default: state_next = (cnt == C_RED) ? NS_G : RED_B;
      endcase
   end

   // a request on the entry edge re-arms the latch for the following green
   always_ff @(posedge clk)
      if (reset) begin
         state       <= RED_B;
         ped_lat_ns  <= 1'b0;
         ped_lat_ew  <= 1'b0;
         walk_gnt_ns <= 1'b0;
         walk_gnt_ew <= 1'b0;
      end else begin
         state       <= state_next;
         ped_lat_ns  <= entry_ns ? ped_req_ns : (ped_lat_ns || ped_req_ns);
         ped_lat_ew  <= entry_ew ? ped_req_ew : (ped_lat_ew || ped_req_ew);
         walk_gnt_ns <= entry_ns ? ped_lat_ns : walk_gnt_ns;
         walk_gnt_ew <= entry_ew ? ped_lat_ew : walk_gnt_ew;
      end

   assign north_south = state == NS_G ? LT_GRN : state == NS_Y ? LT_YEL : LT_RED;
   assign east_west   = state == EW_G ? LT_GRN : state == EW_Y ? LT_YEL : LT_RED;
   assign walk_ns     = state == NS_G && walk_gnt_ns && cnt < C_WALK;
   assign walk_ew     = state == EW_G && walk_gnt_ew && cnt < C_WALK;
   assign phase       = state;
endmodule
